// File: rtl/load_store_unit_if.sv
// Bundles the core request/response handshake and the data_mem port of the load/store unit.
// The slave modport is the LSU side; the master modport is the core plus memory side.
interface load_store_unit_if #(
  parameter int XLEN        = 64,
  parameter int WORD_ADDR_W = 11
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [2:0]             req_funct3;
  logic [XLEN-1:0]        req_addr;
  logic [XLEN-1:0]        req_wdata;
  logic                   resp_valid;
  logic                   resp_err;
  logic [XLEN-1:0]        resp_rdata;
  logic                   mem_rd_en;
  logic [WORD_ADDR_W-1:0] mem_rd_addr;
  logic [3:0]             mem_rd_len;
  logic [XLEN-1:0]        mem_rd_data;
  logic                   mem_wr_en;
  logic [WORD_ADDR_W-1:0] mem_wr_addr;
  logic [XLEN-1:0]        mem_wr_data;
  logic [3:0]             mem_wr_len;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_rd_en, mem_rd_addr, mem_rd_len, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_rd_en, mem_rd_addr, mem_rd_len, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: alignment/range checking, doubleword indexing, load extension
// and read-modify-write merging of sub-doubleword stores against a doubleword data_mem.
module load_store_unit #(
  parameter int XLEN        = 64,
  parameter int WORD_ADDR_W = 11
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam int LOW_W = WORD_ADDR_W + 3;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP, ERR} state_t;

  state_t           state;
  logic             we_p0;
  logic [2:0]       funct3_p0;
  logic [LOW_W-1:0] addr_p0;
  logic [XLEN-1:0]  wdata_p0;
  logic             req_err;
  logic             req_sd;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  return {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  return {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  return {{(XLEN-32){1'b0}}, lane[31:0]};
      default: return lane;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old_word,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size);
    logic [XLEN-1:0] mask;
    case (size)
      2'b00:   mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'b01:   mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'b10:   mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: mask = '1;
    endcase
    return (old_word & ~(mask << {off, 3'b000})) | ((wdata & mask) << {off, 3'b000});
  endfunction

  always_comb begin
    req_err = 1'b0;
    if (bus.req_addr[XLEN-1:LOW_W] != '0) req_err = 1'b1;
    case (bus.req_funct3[1:0])
      2'b01:   if (bus.req_addr[0] != 1'b0)     req_err = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00)  req_err = 1'b1;
      2'b11:   if (bus.req_addr[2:0] != 3'b000) req_err = 1'b1;
      default: ;
    endcase
    if (bus.req_funct3 == 3'b111) req_err = 1'b1;
    if (bus.req_we && bus.req_funct3[2]) req_err = 1'b1;
  end

  assign req_sd          = bus.req_we && (bus.req_funct3 == 3'b011);
  assign bus.req_ready   = (state == IDLE);
  assign bus.mem_rd_addr = addr_p0[LOW_W-1:3];
  assign bus.mem_wr_addr = addr_p0[LOW_W-1:3];
  assign bus.mem_rd_len  = 4'd8;
  assign bus.mem_wr_len  = 4'd8;

  // Request capture and write-data path; an aborted transaction leaves these stale but unused.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      we_p0           <= bus.req_we;
      funct3_p0       <= bus.req_funct3;
      addr_p0         <= bus.req_addr[LOW_W-1:0];
      wdata_p0        <= bus.req_wdata;
      bus.mem_wr_data <= bus.req_wdata;
    end else if (state == WAIT) begin
      bus.mem_wr_data <= store_merge(bus.mem_rd_data, wdata_p0, addr_p0[2:0], funct3_p0[1:0]);
    end
  end

  // Control FSM; every strobe is registered on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_err) begin
              state          <= ERR;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (req_sd) begin
              state          <= WRITE;
              bus.mem_wr_en  <= 1'b1;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state         <= READ;
              bus.mem_rd_en <= 1'b1;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          bus.resp_valid <= 1'b1;
          if (we_p0) begin
            state          <= WRITE;
            bus.mem_wr_en  <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            state          <= RESP;
            bus.resp_rdata <= load_extend(bus.mem_rd_data, addr_p0[2:0], funct3_p0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural doubleword data_mem model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(64), .WORD_ADDR_W(11)) bus ();

  load_store_unit #(.XLEN(64), .WORD_ADDR_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // data_mem model: registered read, write lands at the clock edge
  logic [63:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, acc_cnt = 0, resp_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd_en === 1'b1) rd_cnt++;
    if (bus.mem_wr_en === 1'b1) wr_cnt++;
    if (bus.mem_rd_en === 1'b1 && bus.mem_wr_en === 1'b1) both_cnt++;
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) acc_cnt++;
    if (bus.resp_valid === 1'b1) resp_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] r_data, r_wr_data;
  logic [10:0] r_rd_addr, r_wr_addr;
  logic        r_err;
  int          r_lat, r_rd_at, r_rd_n, r_wr_n;

  task automatic run(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] wdata);
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    r_lat = 0; r_rd_at = 0; r_data = '0; r_err = 1'b0;
    r_wr_data = '0; r_rd_addr = '0; r_wr_addr = '0;
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 8 && r_lat == 0; n++) begin
      if (bus.mem_rd_en === 1'b1) begin
        if (r_rd_at == 0) r_rd_at = n;
        r_rd_addr = bus.mem_rd_addr;
      end
      if (bus.mem_wr_en === 1'b1) begin
        r_wr_addr = bus.mem_wr_addr;
        r_wr_data = bus.mem_wr_data;
      end
      if (bus.resp_valid === 1'b1) begin
        r_lat  = n;
        r_data = bus.resp_rdata;
        r_err  = bus.resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    r_rd_n = rd_cnt - rd0;
    r_wr_n = wr_cnt - wr0;
  endtask

  task automatic load_ok(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] exp);
    run(1'b0, f3, addr, 64'd0);
    check({tag, "_data"}, r_data, exp);
    check({tag, "_lat"}, 64'(r_lat), 64'd3);
    check({tag, "_err"}, 64'(r_err), 64'd0);
  endtask

  task automatic expect_err(input string tag, input logic we, input logic [2:0] f3,
                            input logic [63:0] addr);
    run(we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_err"}, 64'(r_err), 64'd1);
    check({tag, "_data"}, r_data, 64'd0);
    check({tag, "_lat"}, 64'(r_lat), 64'd1);
    check({tag, "_mem"}, 64'(r_rd_n + r_wr_n), 64'd0);
  endtask

  initial begin
    int wr0, acc0, resp0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_idle", 64'(bus.req_ready), 64'd1);
    check("rd_len", 64'(bus.mem_rd_len), 64'd8);
    check("wr_len", 64'(bus.mem_wr_len), 64'd8);

    // SD then LD at 0x40
    run(1'b1, 3'b011, 64'h40, 64'h1122_3344_5566_7788);
    check("sd_lat", 64'(r_lat), 64'd1);
    check("sd_wr_addr", 64'(r_wr_addr), 64'd8);
    check("sd_wr_data", r_wr_data, 64'h1122_3344_5566_7788);
    check("sd_wr_n", 64'(r_wr_n), 64'd1);
    check("sd_rd_n", 64'(r_rd_n), 64'd0);
    check("sd_err", 64'(r_err), 64'd0);
    load_ok("ld40", 3'b011, 64'h40, 64'h1122_3344_5566_7788);
    check("ld40_rd_at", 64'(r_rd_at), 64'd1);
    check("ld40_rd_addr", 64'(r_rd_addr), 64'd8);

    // SB read-modify-write, then lane extraction
    run(1'b1, 3'b000, 64'h43, 64'h0000_0000_0000_00AB);
    check("sb_lat", 64'(r_lat), 64'd3);
    check("sb_rd_addr", 64'(r_rd_addr), 64'd8);
    check("sb_wr_addr", 64'(r_wr_addr), 64'd8);
    check("sb_wr_data", r_wr_data, 64'h1122_3344_AB66_7788);
    check("sb_data", r_data, 64'd0);
    load_ok("lb43", 3'b000, 64'h43, 64'hFFFF_FFFF_FFFF_FFAB);
    load_ok("lbu43", 3'b100, 64'h43, 64'h0000_0000_0000_00AB);
    load_ok("lw44", 3'b010, 64'h44, 64'h0000_0000_1122_3344);
    load_ok("lh46", 3'b001, 64'h46, 64'h0000_0000_0000_1122);
    load_ok("lw40", 3'b010, 64'h40, 64'hFFFF_FFFF_AB66_7788);
    load_ok("lwu40", 3'b110, 64'h40, 64'h0000_0000_AB66_7788);

    // SW and SH merges
    run(1'b1, 3'b010, 64'h44, 64'h5555_5555_DEAD_BEEF);
    check("sw_wr_data", r_wr_data, 64'hDEAD_BEEF_AB66_7788);
    run(1'b1, 3'b001, 64'h42, 64'h0000_0000_0000_BEEF);
    check("sh_wr_data", r_wr_data, 64'hDEAD_BEEF_BEEF_7788);
    load_ok("ld40b", 3'b011, 64'h40, 64'hDEAD_BEEF_BEEF_7788);
    load_ok("lhu42", 3'b101, 64'h42, 64'h0000_0000_0000_BEEF);
    load_ok("lh42", 3'b001, 64'h42, 64'hFFFF_FFFF_FFFF_BEEF);

    // last doubleword of the space
    run(1'b1, 3'b011, 64'h3FF8, 64'hCAFE_F00D_1234_5678);
    check("sd_top_wr_addr", 64'(r_wr_addr), 64'd2047);
    load_ok("ld_top", 3'b011, 64'h3FF8, 64'hCAFE_F00D_1234_5678);

    // error cases
    expect_err("lw_mis", 1'b0, 3'b010, 64'h42);
    expect_err("sd_range", 1'b1, 3'b011, 64'h4004);
    expect_err("ld_range", 1'b0, 3'b011, 64'h4000);
    expect_err("ld_hi", 1'b0, 3'b011, 64'h8000_0000_0000_0040);
    expect_err("f3_111", 1'b0, 3'b111, 64'h40);
    expect_err("st_bu", 1'b1, 3'b100, 64'h40);
    expect_err("lh_mis", 1'b0, 3'b001, 64'h41);

    // reset during WAIT aborts a sub-word store
    run(1'b1, 3'b011, 64'h48, 64'h0F0E_0D0C_0B0A_0908);
    wr0 = wr_cnt;
    bus.req_we = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 64'h48;
    bus.req_wdata = 64'h1234; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_resp_err", 64'(bus.resp_err), 64'd0);
    check("abort_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("abort_rdata", bus.resp_rdata, 64'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    check("abort_no_write", 64'(wr_cnt - wr0), 64'd0);
    load_ok("ld48", 3'b011, 64'h48, 64'h0F0E_0D0C_0B0A_0908);

    // req_valid held across three loads
    acc0 = acc_cnt;
    resp0 = resp_cnt;
    bus.req_we = 1'b0; bus.req_funct3 = 3'b011; bus.req_addr = 64'h40;
    bus.req_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("held_accepts", 64'(acc_cnt - acc0), 64'd3);
    check("held_resps", 64'(resp_cnt - resp0), 64'd3);
    check("held_ready", 64'(bus.req_ready), 64'd1);

    check("rd_wr_overlap", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
